// File: rtl/timer_switch_multi.sv
// timer_switch_multi: independent staircase-light timer channels with
// per-channel press load/retrigger, end-of-period warning and long-press hold-off.
`default_nettype none

module timer_switch_multi #(
  parameter  int CHANNELS = 4,
  parameter  int ON_TIME  = 20,
  parameter  int WARN     = 3,
  parameter  int HOLD_OFF = 8,
  localparam int CNT_W    = $clog2(ON_TIME + 1)
) (
  input  logic                      clock_1Hz,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       btn_ext,
  input  logic [CHANNELS-1:0]       retrig,
  output logic [CHANNELS-1:0]       light,
  output logic [CHANNELS-1:0]       warn,
  output logic [CHANNELS*CNT_W-1:0] remaining,
  output logic                      any_on
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ON_TIME);
  localparam logic [CNT_W-1:0] WARN_VAL = CNT_W'(WARN);
  localparam logic             HOLD_EN  = (HOLD_OFF != 0);
  localparam logic [7:0]       HOLD_CMP = 8'((HOLD_OFF == 0) ? 0 : HOLD_OFF - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       hold_q, hold_d;
    logic             btn_prev_q, btn_prev_d;
    logic             press, kill;

    always_ff @(posedge clock_1Hz or negedge reset_n) begin
      if (!reset_n) begin
        count_q    <= '0;
        hold_q     <= '0;
        // Reset high so a button held through reset release does not count as a press.
        btn_prev_q <= 1'b1;
      end else begin
        count_q    <= count_d;
        hold_q     <= hold_d;
        btn_prev_q <= btn_prev_d;
      end
    end

    always_comb begin
      press      = btn_ext[i] & ~btn_prev_q;
      // Hold-off fires only on the single edge where hold crosses the threshold.
      kill       = HOLD_EN & btn_ext[i] & (hold_q == HOLD_CMP);
      btn_prev_d = btn_ext[i];

      if (kill)
        count_d = '0;
      else if (press && ((count_q == '0) || retrig[i]))
        count_d = LOAD_VAL;
      else if (count_q != '0)
        count_d = count_q - 1'b1;
      else
        count_d = '0;

      if (!btn_ext[i])
        hold_d = '0;
      else if (hold_q == 8'hFF)
        hold_d = hold_q;
      else
        hold_d = hold_q + 8'd1;
    end

    assign light[i]                        = (count_q != '0);
    assign warn[i]                         = (count_q != '0) && (count_q <= WARN_VAL);
    assign remaining[i*CNT_W +: CNT_W]     = count_q;
  end : g_ch

  assign any_on = |light;

endmodule

`default_nettype wire

// File: tb/tb_timer_switch_multi.sv
// Directed bench for timer_switch_multi with a per-cycle behavioural model.
`default_nettype none

module tb_timer_switch_multi;

  localparam int CH       = 4;
  localparam int ON_TIME  = 20;
  localparam int WARN     = 3;
  localparam int HOLD_OFF = 8;
  localparam int CNT_W    = 5;

  logic                clk;
  logic                rst_n;
  logic [CH-1:0]       btn;
  logic [CH-1:0]       rtg;
  logic [CH-1:0]       light;
  logic [CH-1:0]       warn;
  logic [CH*CNT_W-1:0] remaining;
  logic                any_on;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt  [CH];
  int m_hold [CH];
  bit m_prev [CH];

  timer_switch_multi #(
    .CHANNELS(CH), .ON_TIME(ON_TIME), .WARN(WARN), .HOLD_OFF(HOLD_OFF)
  ) dut (
    .clock_1Hz(clk),
    .reset_n  (rst_n),
    .btn_ext  (btn),
    .retrig   (rtg),
    .light    (light),
    .warn     (warn),
    .remaining(remaining),
    .any_on   (any_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rem(input int i);
    logic [CH*CNT_W-1:0] r;
    r = remaining;
    return int'(r[i*CNT_W +: CNT_W]);
  endfunction

  // Model: remaining on-time per channel, in plain integer terms.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i]  <= 0;
        m_hold[i] <= 0;
        m_prev[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        int  nxt;
        bit  pressed;
        bit  long_press;
        pressed    = btn[i] && !m_prev[i];
        long_press = (HOLD_OFF != 0) && btn[i] && (m_hold[i] == HOLD_OFF - 1);
        if (long_press)                                nxt = 0;
        else if (pressed && (m_cnt[i] == 0 || rtg[i])) nxt = ON_TIME;
        else                                           nxt = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        m_cnt[i]  <= nxt;
        m_hold[i] <= btn[i] ? ((m_hold[i] >= 255) ? 255 : m_hold[i] + 1) : 0;
        m_prev[i] <= btn[i];
      end
    end
  end

  always @(negedge clk) begin
    int any;
    any = 0;
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("light[%0d]", i), int'(light[i]), int'(m_cnt[i] > 0));
      chk($sformatf("warn[%0d]", i), int'(warn[i]), int'(m_cnt[i] >= 1 && m_cnt[i] <= WARN));
      chk($sformatf("remaining[%0d]", i), rem(i), m_cnt[i]);
      if (m_cnt[i] > 0) any = 1;
    end
    chk("any_on", int'(any_on), any);
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    rtg   = 4'b0010;
    #1;
    chk("reset light", int'(light), 0);
    chk("reset remaining", int'(remaining), 0);
    chk("reset any_on", int'(any_on), 0);

    // Channel 3 held high across reset release must not trigger.
    btn[3] = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    chk("held through reset light3", int'(light[3]), 0);
    btn[3] = 1'b0;
    ticks(1);

    // Simultaneous press on ch0 (one-shot) and ch1 (retrigger), held 4 cycles.
    btn[1:0] = 2'b11;
    ticks(1);                                   // e1
    chk("simul lights", int'(light[1:0]), 3);
    chk("simul any_on", int'(any_on), 1);
    chk("ch0 load", rem(0), 20);
    ticks(3);                                   // e4
    btn[1:0] = 2'b00;
    ticks(7);                                   // e11
    chk("ch0 rem before 2nd press", rem(0), 10);
    btn[0] = 1'b1;
    ticks(3);                                   // e14
    chk("ch0 one-shot ignores press", rem(0), 7);
    btn[0] = 1'b0;
    ticks(2);                                   // e16
    chk("ch1 rem before retrigger", rem(1), 5);
    btn[1] = 1'b1;
    ticks(1);                                   // e17
    chk("ch1 reload", rem(1), 20);
    btn[1] = 1'b0;
    ticks(3);                                   // e20
    chk("ch0 last edge light", int'(light[0]), 1);
    chk("ch0 last edge warn", int'(warn[0]), 1);
    ticks(1);                                   // e21
    chk("ch0 off after 20", int'(light[0]), 0);
    ticks(15);                                  // e36
    chk("ch1 still on", int'(light[1]), 1);
    ticks(1);                                   // e37
    chk("ch1 off", int'(light[1]), 0);
    chk("all off any_on", int'(any_on), 0);

    // One-shot press landing when remaining==1 is ignored.
    btn[0] = 1'b1;
    ticks(1);
    btn[0] = 1'b0;
    ticks(19);
    chk("ch0 rem==1", rem(0), 1);
    btn[0] = 1'b1;
    ticks(1);
    chk("press at rem1 ignored", int'(light[0]), 0);
    btn[0] = 1'b0;
    ticks(1);

    // Long press on ch2: hold-off clears on the 8th high edge, once.
    btn[2] = 1'b1;
    ticks(1);
    chk("ch2 load", rem(2), 20);
    ticks(6);
    chk("ch2 before hold-off", rem(2), 14);
    ticks(1);
    chk("ch2 hold-off clear", rem(2), 0);
    ticks(4);
    chk("ch2 no retrigger while held", int'(light[2]), 0);
    btn[2] = 1'b0;
    ticks(1);
    btn[2] = 1'b1;
    ticks(1);
    chk("ch2 re-press", rem(2), 20);
    btn[2] = 1'b0;
    ticks(3);

    // Async reset mid-period on ch0 at remaining==12.
    btn[0] = 1'b1;
    ticks(1);
    btn[0] = 1'b0;
    ticks(8);
    chk("ch0 rem 12", rem(0), 12);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset light", int'(light), 0);
    chk("async reset remaining", int'(remaining), 0);
    chk("async reset any_on", int'(any_on), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
